de1_arm_nios_debug_host_shifter: RTL

//  Host-side driver for the Nios II debug slave's virtual-JTAG interface (initiator end).
//  - Accepts one {IR, DR} debug command on a valid/ready port.
//  - Generates the UIR/CDR/SDR/UDR/RTI virtual states plus tck/tdi, and captures tdo.
//  - Returns the captured DR word on a valid/ready response port.
//  - Drives the debug slave in-fabric, with no physical JTAG hub.

---
 rtl/dbg_host_pkg.sv | 23 ++
 rtl/dbg_host_tck_gen.sv | 40 ++++
 rtl/de1_arm_nios_debug_host_shifter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/dbg_host_pkg.sv
// Shared types and constants for the Nios II debug host shifter.
// Holds the FSM state encoding, default widths and debug instruction codes.
package dbg_host_pkg;

  localparam int DBG_IR_W = 2;
  localparam int DBG_DR_W = 38;

  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UIR  = 3'd1,
    CDR  = 3'd2,
    SDR  = 3'd3,
    UDR  = 3'd4,
    RTI  = 3'd5,
    RSP  = 3'd6
  } state_t;

endpackage

// File: rtl/dbg_host_tck_gen.sv
// Virtual tck generator: toggles tck every TCK_DIV clk cycles while run is high,
// holds it low otherwise, and flags the edge that is about to happen (rise/fall).
module dbg_host_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tck,
  output logic rise,
  output logic fall
);

  localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic             wrap;

  // rise/fall are strobes for the same clk edge on which tck toggles
  assign wrap = run && (div == DIV_W'(TCK_DIV - 1));
  assign rise = wrap && !tck;
  assign fall = wrap && tck;

  // Divider and tck register; restart from a low tck whenever run drops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
      tck <= 1'b0;
    end else if (!run) begin
      div <= '0;
      tck <= 1'b0;
    end else if (wrap) begin
      div <= '0;
      tck <= ~tck;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/de1_arm_nios_debug_host_shifter.sv
// Host-side virtual-JTAG driver for the Nios II debug slave: one {IR, DR} command
// in, UIR/CDR/SDR/UDR/RTI sequence out, captured DR word back. Macro: DBG_HOST_IR_CACHE_EN.
module de1_arm_nios_debug_host_shifter
  import dbg_host_pkg::*;
#(
  parameter int IR_W    = DBG_IR_W,
  parameter int DR_W    = DBG_DR_W,
  parameter int TCK_DIV = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [IR_W-1:0] cmd_ir,
  input  logic [DR_W-1:0] cmd_dr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DR_W-1:0] rsp_dr,
  output logic            busy,
  output logic            vj_tck,
  output logic            vj_tdi,
  input  logic            vj_tdo,
  output logic [IR_W-1:0] vj_ir_in,
  output logic            vj_uir,
  output logic            vj_cdr,
  output logic            vj_sdr,
  output logic            vj_udr,
  output logic            vj_rti
);

  localparam int CNT_W = $clog2(DR_W + 1);

  state_t            state;
  state_t            state_nxt;
  logic [DR_W-1:0]   shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              run;
  logic              rise;
  logic              fall;
  logic              accept;
  logic              ir_hit;
  logic              sdr_done;

  assign run      = (state != IDLE) && (state != RSP);
  assign accept   = (state == IDLE) && cmd_valid;
  assign sdr_done = (bit_cnt == CNT_W'(DR_W));

  dbg_host_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (run),
    .tck     (vj_tck),
    .rise    (rise),
    .fall    (fall)
  );

`ifdef DBG_HOST_IR_CACHE_EN
  logic            cache_valid;
  logic [IR_W-1:0] cache_ir;

  assign ir_hit = cache_valid && (cmd_ir == cache_ir);

  // Remember the IR of the last UIR that ran to completion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cache_valid <= 1'b0;
      cache_ir    <= '0;
    end else if ((state == UIR) && fall) begin
      cache_valid <= 1'b1;
      cache_ir    <= vj_ir_in;
    end else begin
      cache_valid <= cache_valid;
      cache_ir    <= cache_ir;
    end
  end
`else
  assign ir_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: every tck-domain state advances on a fall strobe
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = ir_hit ? CDR : UIR;
               else           state_nxt = IDLE;
      UIR:     if (fall) state_nxt = CDR; else state_nxt = UIR;
      CDR:     if (fall) state_nxt = SDR; else state_nxt = CDR;
      SDR:     if (fall && sdr_done) state_nxt = UDR; else state_nxt = SDR;
      UDR:     if (fall) state_nxt = RTI; else state_nxt = UDR;
      RTI:     if (fall) state_nxt = RSP; else state_nxt = RTI;
      RSP:     if (rsp_ready) state_nxt = IDLE; else state_nxt = RSP;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch and DR shift on tck rise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vj_ir_in  <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (accept) begin
      vj_ir_in  <= cmd_ir;
      shift_reg <= cmd_dr;
      bit_cnt   <= '0;
    end else if ((state == SDR) && rise) begin
      shift_reg <= {vj_tdo, shift_reg[DR_W-1:1]};
      bit_cnt   <= bit_cnt + CNT_W'(1);
    end else begin
      shift_reg <= shift_reg;
      bit_cnt   <= bit_cnt;
    end
  end

  // tdi presents the next bit on each fall; it is forced low once SDR ends
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vj_tdi <= 1'b0;
    end else if (fall && (state == CDR)) begin
      vj_tdi <= shift_reg[0];
    end else if (fall && (state == SDR)) begin
      vj_tdi <= sdr_done ? 1'b0 : shift_reg[0];
    end else begin
      vj_tdi <= vj_tdi;
    end
  end

  // Response word is captured as RTI hands over to RSP and holds until the next one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  rsp_dr <= '0;
    else if ((state == RTI) && fall) rsp_dr <= shift_reg;
    else                           rsp_dr <= rsp_dr;
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RSP);
  assign vj_uir    = (state == UIR);
  assign vj_cdr    = (state == CDR);
  assign vj_sdr    = (state == SDR);
  assign vj_udr    = (state == UDR);
  assign vj_rti    = (state == RTI);

endmodule
